// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data SRAM arbiter (package arm_pkg).
package arm_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      OWN_IF  = 2'd1,
      OWN_MEM = 2'd2
   } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection between fetch and memory-stage requests.
// MEM_ARB_ROUND_ROBIN_EN: on a conflict, grant whoever was not granted last;
// otherwise MEM always beats IF on a conflict.
module arb_pick
   import arm_pkg::*;
(
   input  logic       if_req,
   input  logic       mem_req,
   input  arb_owner_t last_owner,
   output arb_owner_t winner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
   // Fixed priority ignores the grant history.
   logic unused_last_owner;
   assign unused_last_owner = ^last_owner;
`endif

   // Sole requester wins; a conflict is resolved by the configured policy.
   always_comb begin
      winner = NONE;
      if (if_req && mem_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         winner = (last_owner == OWN_MEM) ? OWN_IF : OWN_MEM;
`else
         winner = OWN_MEM;
`endif
      end else if (mem_req) begin
         winner = OWN_MEM;
      end else if (if_req) begin
         winner = OWN_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port SRAM between instruction fetch
// (read only) and the memory stage (read/write). One access at a time:
// IDLE -> ACCESS (WAIT_CYCLES cycles) -> RESP (one-cycle ready pulse).
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternating grant on conflict).
module mem_arbiter
   import arm_pkg::*;
#(
   parameter int ADDR_W      = 16,   // SRAM word-address width, at most 30
   parameter int WAIT_CYCLES = 4     // SRAM latency, 1..15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ready,
   output logic [31:0]       if_rdata,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              mem_stall,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   arb_state_t          state_q, state_d;
   arb_owner_t          owner_q, owner_d;
   arb_owner_t          winner;
   arb_owner_t          last_owner;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
   logic [WORD_W-1:0]   mem_rdata_q, mem_rdata_d;

   // Byte-offset bits and bits above the SRAM size are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr, mem_addr};

   arb_pick u_pick (
      .if_req     (if_req),
      .mem_req    (mem_req),
      .last_owner (last_owner),
      .winner     (winner)
   );

`ifdef MEM_ARB_ROUND_ROBIN_EN
   arb_owner_t last_owner_q, last_owner_d;

   assign last_owner_d = (state_q == IDLE && winner != NONE) ? winner : last_owner_q;
   assign last_owner   = last_owner_q;

   // Remember who was granted last so a conflict alternates between stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner_q <= OWN_IF;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`else
   assign last_owner = OWN_IF;
`endif

   // Next-state logic: grant in IDLE, count down latency in ACCESS, pulse in RESP.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         IDLE: begin
            if (winner != NONE) begin
               owner_d = winner;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
               if (winner == OWN_MEM) begin
                  addr_d  = mem_addr[ADDR_W+1:2];
                  we_d    = mem_we;
                  wdata_d = mem_wdata;
               end else begin
                  addr_d  = if_addr[ADDR_W+1:2];
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               // SRAM data is only valid in the final access cycle.
               if (owner_q == OWN_MEM) begin
                  mem_rdata_d = we_q ? '0 : sram_rdata;
               end else begin
                  if_rdata_d = sram_rdata;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            owner_d = NONE;
            state_d = IDLE;
         end
         default: begin
            owner_d = NONE;
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-operand registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= NONE;
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign sram_en    = (state_q == ACCESS);
   assign sram_we    = (state_q == ACCESS) && we_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

   assign if_ready   = (state_q == RESP) && (owner_q == OWN_IF);
   assign mem_ready  = (state_q == RESP) && (owner_q == OWN_MEM);
   assign if_rdata   = if_rdata_q;
   assign mem_rdata  = mem_rdata_q;

   // Stalls follow the request level; forced low while reset is held.
   assign if_stall   = if_req  & ~if_ready  & ~rst;
   assign mem_stall  = mem_req & ~mem_ready & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases followed by random
// traffic, checked against a transaction-level model of grant order,
// latency and SRAM contents.
module tb_mem_arbiter;

   localparam int AW    = 16;
   localparam int WC    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int SLOT  = WC + 2;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [31:0]   if_addr;
   logic          if_ready;
   logic [31:0]   if_rdata;
   logic          if_stall;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ready;
   logic [31:0]   mem_rdata;
   logic          mem_stall;
   logic          sram_en;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] sram_mem [0:DEPTH-1];
   logic [31:0] ref_mem  [0:DEPTH-1];
   int          en_cnt;
   bit          last_mem;
   logic [31:0] last_if_rd;
   logic [31:0] last_mem_rd;

   mem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_ready   (if_ready),
      .if_rdata   (if_rdata),
      .if_stall   (if_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .mem_stall  (mem_stall),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: data is only meaningful in the last access cycle, junk before.
   always @(posedge clk or posedge rst) begin
      if (rst)          en_cnt <= 0;
      else if (sram_en) en_cnt <= en_cnt + 1;
      else              en_cnt <= 0;
   end
   assign sram_rdata = (sram_en && en_cnt == WC - 1) ? sram_mem[sram_addr] : ~sram_mem[sram_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] word_of(input logic [31:0] byte_addr);
      return AW'((byte_addr >> 2) % DEPTH);
   endfunction

   function automatic logic [31:0] model_access(input logic [AW-1:0] wa, input bit we,
                                                input logic [31:0] wd);
      if (we) begin
         ref_mem[wa] = wd;
         return 32'h0;
      end
      return ref_mem[wa];
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      r = $urandom;
      r[AW+1:2] = AW'($urandom_range(0, 7));
      return r;
   endfunction

   // One transaction: raise the requested ports together, follow every cycle
   // until all requested readies arrive, comparing against the model.
   task automatic txn(input bit do_mem, input bit m_we, input logic [31:0] m_addr,
                      input logic [31:0] m_wd, input bit do_if, input logic [31:0] i_addr);
      logic [AW-1:0] wa_mem, wa_if, a1, a2, ea;
      bit            mem_first, we1, we2, ew, done_mem, done_if;
      logic [31:0]   wd1, wd2, ewd, exp_mem_rd, exp_if_rd;
      int            n_mem_exp, n_if_exp, en_seen, n;
      wa_mem = word_of(m_addr);
      wa_if  = word_of(i_addr);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      mem_first = do_mem && (!do_if || !last_mem);
`else
      mem_first = do_mem;
`endif
      exp_mem_rd = last_mem_rd;
      exp_if_rd  = last_if_rd;
      n_mem_exp  = mem_first ? SLOT : 2 * SLOT;
      n_if_exp   = mem_first ? 2 * SLOT : SLOT;
      if (mem_first) begin
         exp_mem_rd = model_access(wa_mem, m_we, m_wd);
         if (do_if) exp_if_rd = model_access(wa_if, 1'b0, 32'h0);
         a1 = wa_mem; we1 = m_we; wd1 = m_wd;
         a2 = wa_if;  we2 = 1'b0; wd2 = 32'h0;
         last_mem = !do_if;
      end else begin
         exp_if_rd = model_access(wa_if, 1'b0, 32'h0);
         if (do_mem) exp_mem_rd = model_access(wa_mem, m_we, m_wd);
         a1 = wa_if;  we1 = 1'b0; wd1 = 32'h0;
         a2 = wa_mem; we2 = m_we; wd2 = m_wd;
         last_mem = do_mem;
      end

      mem_req = do_mem; mem_we = m_we; mem_addr = m_addr; mem_wdata = m_wd;
      if_req  = do_if;  if_addr = i_addr;
      done_mem = !do_mem;
      done_if  = !do_if;
      en_seen  = 0;
      n        = 0;
      while (!(done_mem && done_if) && n < 4 * SLOT) begin
         n++;
         @(negedge clk);
         if (sram_en) begin
            en_seen++;
            ea  = (en_seen <= WC) ? a1 : a2;
            ew  = (en_seen <= WC) ? we1 : we2;
            ewd = (en_seen <= WC) ? wd1 : wd2;
            chk("sram_addr", 32'(sram_addr), 32'(ea));
            chk("sram_we", 32'(sram_we), 32'(ew));
            if (ew) chk("sram_wdata", sram_wdata, ewd);
            if (sram_we) sram_mem[sram_addr] = sram_wdata;
         end
         if (do_mem && !done_mem && mem_ready === 1'b1) begin
            chk("mem_latency", 32'(n), 32'(n_mem_exp));
            chk("mem_rdata", mem_rdata, exp_mem_rd);
            chk("mem_stall_at_ready", 32'(mem_stall), 32'd0);
            done_mem = 1'b1;
         end else if (do_mem && !done_mem) begin
            chk("mem_stall", 32'(mem_stall), 32'd1);
         end else begin
            chk("mem_ready_quiet", 32'(mem_ready), 32'd0);
         end
         if (do_if && !done_if && if_ready === 1'b1) begin
            chk("if_latency", 32'(n), 32'(n_if_exp));
            chk("if_rdata", if_rdata, exp_if_rd);
            chk("if_stall_at_ready", 32'(if_stall), 32'd0);
            done_if = 1'b1;
         end else if (do_if && !done_if) begin
            chk("if_stall", 32'(if_stall), 32'd1);
         end else begin
            chk("if_ready_quiet", 32'(if_ready), 32'd0);
         end
         @(posedge clk);
         #1;
         if (done_mem) mem_req = 1'b0;
         if (done_if)  if_req  = 1'b0;
      end
      chk("txn_timeout", 32'(done_mem && done_if), 32'd1);
      chk("sram_cycles", 32'(en_seen), 32'((int'(do_mem) + int'(do_if)) * WC));
      last_mem_rd = exp_mem_rd;
      last_if_rd  = exp_if_rd;
      chk("mem_rdata_hold", mem_rdata, last_mem_rd);
      chk("if_rdata_hold", if_rdata, last_if_rd);
   endtask

   initial begin
      logic [31:0] ra, rb, rw;
      bit          dm, di, rwe;
      int          kind;

      for (int i = 0; i < DEPTH; i++) begin
         sram_mem[i] = $urandom;
         ref_mem[i]  = sram_mem[i];
      end
      sram_mem[4] = 32'hDEAD_BEEF;
      ref_mem[4]  = 32'hDEAD_BEEF;
      last_mem    = 1'b0;
      last_if_rd  = 32'h0;
      last_mem_rd = 32'h0;

      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'h0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;

      // Reset state
      @(negedge clk);
      chk("rst_sram_en", 32'(sram_en), 32'd0);
      chk("rst_sram_we", 32'(sram_we), 32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed: MEM read, MEM write then IF read-back, conflicts, address wrap
      txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
      txn(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0);
      txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0020);
      txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0000_0020);
      txn(1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 1'b1, 32'h0000_0024);
      txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'h0);

      // Reset during the second ACCESS cycle of an IF read
      if_addr = 32'h0000_0044;
      if_req  = 1'b1;
      @(negedge clk);
      chk("pre_rst_idle", 32'(sram_en), 32'd0);
      @(negedge clk);
      chk("pre_rst_access1", 32'(sram_en), 32'd1);
      @(negedge clk);
      chk("pre_rst_access2", 32'(sram_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_sram_en", 32'(sram_en), 32'd0);
      chk("midrst_if_ready", 32'(if_ready), 32'd0);
      chk("midrst_if_stall", 32'(if_stall), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_mem    = 1'b0;
      last_if_rd  = 32'h0;
      last_mem_rd = 32'h0;
      chk("postrst_if_rdata", if_rdata, 32'd0);
      chk("postrst_mem_rdata", mem_rdata, 32'd0);
      txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0044);

      // Random traffic over a small window of words so accesses collide
      for (int k = 0; k < 40; k++) begin
         kind = int'($urandom_range(0, 2));
         dm   = (kind != 1);
         di   = (kind != 0);
         ra   = rand_addr();
         rb   = rand_addr();
         rw   = $urandom;
         rwe  = 1'($urandom_range(0, 1));
         txn(dm, rwe, ra, rw, di, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
